// File: rtl/toggle_bank.sv
// toggle_bank: a bank of N independent channels, each turning an asynchronous
// request input into a registered state bit.
//
// Per channel: sig -> 2-flop synchroniser (s1, s2) -> filtered level f ->
// rising-edge detect (f & ~fp). A toggle-mode channel flips on each rising
// edge. A momentary-mode channel copies f every cycle.
//
// Build option: define TOGGLE_BANK_DEBOUNCE_EN to put a DB_CYCLES debounce
// counter in front of f. Without it, f is s2 delayed by one register.
//
// Parameters:
//   N          channel count (1..32)
//   DB_CYCLES  stable cycles needed to accept a level change (1..65535)
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-low reset
//   sig[N]       asynchronous request inputs
//   mode[N]      0 = toggle, 1 = momentary
//   clr          clears all toggle-mode channels
//   load         loads load_val into the toggle-mode channels (clr wins)
//   load_val[N]  value written by load
//   tog[N]       registered channel states
//   changed[N]   high for one cycle after the tog bit changes
//   any_changed  OR of changed, aligned with changed
module toggle_bank #(
    parameter int N         = 4,
    parameter int DB_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] sig,
    input  logic [N-1:0] mode,
    input  logic         clr,
    input  logic         load,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] tog,
    output logic [N-1:0] changed,
    output logic         any_changed
);

    // Stop elaboration if a parameter is out of range.
    if (N < 1 || N > 32 || DB_CYCLES < 1 || DB_CYCLES > 65535) begin : g_param_check
        $error("toggle_bank: parameter out of range");
    end

    logic [N-1:0] s1;
    logic [N-1:0] s2;
    logic [N-1:0] f;
    logic [N-1:0] fp;
    logic [N-1:0] arm;
    logic [N-1:0] edge_ok;
    logic [N-1:0] tog_next;
    logic [N-1:0] tog_diff;
    logic         live;

`ifdef TOGGLE_BANK_DEBOUNCE_EN
    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

    logic [CW-1:0] cnt [N];

    // The counter holds how many consecutive cycles s2 has disagreed with f.
    // On the DB_CYCLES-th such cycle, f takes the new level.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (!rst) begin
                f[i]   <= 1'b0;
                cnt[i] <= '0;
            end else if (s2[i] == f[i]) begin
                cnt[i] <= '0;
            end else if (cnt[i] == DB_LAST) begin
                f[i]   <= s2[i];
                cnt[i] <= '0;
            end else begin
                cnt[i] <= cnt[i] + CW'(1);
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!rst) begin
            f <= '0;
        end else begin
            f <= s2;
        end
    end
`endif

    // Reset clears the whole pipeline to 0. If sig is high at release, f
    // rises while fp is still 0, which looks like a real rising edge. To
    // block that, each channel is armed only after it has been seen low all
    // the way down the pipe. 'live' marks that s1 holds a real sample.
    // Until then, a low s1 means nothing.
    assign edge_ok  = f & ~fp & arm;
    assign tog_diff = tog_next ^ tog;

    always_comb begin
        tog_next = tog;
        for (int i = 0; i < N; i++) begin
            if (mode[i]) begin
                tog_next[i] = f[i];
            end else if (clr) begin
                tog_next[i] = 1'b0;
            end else if (load) begin
                tog_next[i] = load_val[i];
            end else if (edge_ok[i]) begin
                tog_next[i] = ~tog[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1          <= '0;
            s2          <= '0;
            fp          <= '0;
            arm         <= '0;
            live        <= 1'b0;
            tog         <= '0;
            changed     <= '0;
            any_changed <= 1'b0;
        end else begin
            s1          <= sig;
            s2          <= s1;
            fp          <= f;
            live        <= 1'b1;
            arm         <= arm | ({N{live}} & ~s1 & ~s2 & ~f & ~fp);
            tog         <= tog_next;
            changed     <= tog_diff;
            any_changed <= |tog_diff;
        end
    end

endmodule

// File: doc/toggle_bank.md
TOGGLE_BANK -- requirements
Module: toggle_bank

Interface
REQ-001 SHALL have parameter N, default 4: channel count, 1..32.
REQ-002 SHALL have parameter DB_CYCLES, default 4: consecutive stable cycles needed to accept a level change, 1..65535.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port sig, input, N: asynchronous per-channel request inputs.
REQ-006 SHALL have port mode, input, N: per-channel mode; 0 = toggle, 1 = momentary (tog follows the filtered level).
REQ-007 SHALL have port clr, input, 1: synchronous clear of all toggle-mode channels.
REQ-008 SHALL have port load, input, 1: loads load_val into the toggle-mode channels.
REQ-009 SHALL have port load_val, input, N: value written by load.
REQ-010 SHALL have port tog, output, N: registered channel states.
REQ-011 SHALL have port changed, output, N: one-cycle pulse in the cycle after any tog bit changes.
REQ-012 SHALL have port any_changed, output, 1: registered OR of the next value of changed, so it is aligned with changed.

Function
REQ-013 Each sig bit SHALL pass through a 2-flop synchroniser (s1, s2) before any other use.
REQ-014 Filtered level f[i] SHALL follow s2[i] as defined by the debounce configuration (REQ-027/028).
REQ-015 Rising edge e[i] SHALL equal f[i] & ~fp[i], where fp[i] is f[i] registered one cycle.
REQ-016 In toggle mode, tog[i] SHALL invert at the clock edge on which e[i] = 1; a held-high sig SHALL produce exactly one toggle.
REQ-017 In momentary mode, tog[i] SHALL be loaded with f[i] every cycle; clr, load and e[i] SHALL be ignored for that channel.
REQ-018 Priority per toggle-mode channel: rst > clr > load > e[i].
REQ-019 clr = 1 SHALL write 0 to tog[i]; an edge in the same cycle SHALL be discarded, not deferred.
REQ-020 load = 1 (with clr = 0) SHALL write load_val[i] to tog[i]; a simultaneous edge SHALL be discarded.
REQ-021 changed[i] SHALL be 1 for exactly one cycle following each cycle in which tog[i] took a different value, whatever the cause, including a mode change.
REQ-022 A mode bit change SHALL take effect at the next edge; tog SHALL NOT be cleared on a mode change.
REQ-023 Channels SHALL be fully independent; simultaneous edges on all N channels SHALL all be honoured in the same cycle.

Reset
REQ-024 While rst = 0 at a rising edge, s1, s2, f, fp, the debounce counters, tog, changed and any_changed SHALL all be cleared to 0.
REQ-025 Reset mid-debounce SHALL discard the partial count; reset with sig held high SHALL NOT produce a toggle on release unless sig goes low and then high again after fp has settled.
REQ-026 On the first edge after reset release, changed SHALL be 0.

Configuration
REQ-027 With TOGGLE_BANK_DEBOUNCE_EN defined: each channel has a counter of width clog2(DB_CYCLES+1).
- The counter clears whenever s2[i] == f[i].
- Otherwise the counter increments.
- When s2[i] has differed from f[i] for DB_CYCLES consecutive cycles, f[i] <= s2[i] and the counter clears.
- Glitches shorter than DB_CYCLES cycles SHALL be ignored.
REQ-028 Without TOGGLE_BANK_DEBOUNCE_EN: f[i] SHALL equal s2[i] registered one cycle; no counters are synthesised; DB_CYCLES is unused.
REQ-029 Without debounce, tog SHALL update at the 4th rising edge after sig is first sampled high. With debounce, this latency SHALL increase by DB_CYCLES-1 cycles.

Verification
REQ-030 Debounce off, N=4:
- Stimulus: sig=0001 held for 10 cycles.
- Response: tog=0001 after 4 edges; changed=0001 for one cycle; no further change.
REQ-031 Debounce on, DB_CYCLES=4:
- Stimulus: a 3-cycle pulse on sig[1], then an 8-cycle pulse on sig[1].
- Response: the first pulse is ignored; the second sets tog[1]=1; any_changed pulses once.
REQ-032 Same-cycle conflict:
- Stimulus: tog=1111, mode=0000; clr=1, load=1, load_val=0101 and an edge on sig[0], all in the same cycle.
- Response: tog=0000; changed=1111.
REQ-033 Momentary mode:
- Stimulus: mode=0100; sig[2] high 6 cycles, then low.
- Response: tog[2] tracks the filtered level (high then low); changed[2] pulses twice; clr has no effect on ch2.
REQ-034 Reset mid-operation:
- Stimulus: rst=0 asserted while sig=1111 is held and debounce is in progress; then release.
- Response: all outputs 0; no toggle until each sig goes low and then high.
REQ-035 Simultaneous edges:
- Stimulus: rising edges on all four sig bits in the same cycle, twice.
- Response: tog goes 0000 -> 1111 -> 0000; changed=1111 after each transition.
